// File: rtl/flash_read_arbiter_pkg.sv
// Shared types and widths for the flash read arbiter.
package flash_read_arbiter_pkg;

  localparam int unsigned FLASH_ADDR_W = 23;
  localparam int unsigned FLASH_DATA_W = 32;
  localparam logic [3:0]  FLASH_BYTEENABLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DATA
  } arb_state_t;

endpackage

// File: rtl/flash_read_arbiter_if.sv
// Requester and flash Avalon-MM read signals shared by the arbiter.
// The arbiter connects to the slave modport; the requesters/flash model use master.
interface flash_read_arbiter_if #(
  parameter int unsigned ADDR_W = flash_read_arbiter_pkg::FLASH_ADDR_W,
  parameter int unsigned DATA_W = flash_read_arbiter_pkg::FLASH_DATA_W
);
  logic              m0_read;
  logic [ADDR_W-1:0] m0_address;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  logic              m1_read;
  logic [ADDR_W-1:0] m1_address;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [3:0]        flash_mem_byteenable;
  logic              flash_mem_waitrequest;
  logic [DATA_W-1:0] flash_mem_readdata;
  logic              flash_mem_readdatavalid;

  modport slave (
    input  m0_read, m0_address, m1_read, m1_address,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output flash_mem_read, flash_mem_address, flash_mem_byteenable,
    input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
  );

  modport master (
    output m0_read, m0_address, m1_read, m1_address,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  flash_mem_read, flash_mem_address, flash_mem_byteenable,
    output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
  );
endinterface

// File: rtl/flash_read_arbiter_rr_grant2.sv
// Two-way round-robin grant: combinational pick, registered priority bit.
module rr_grant2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       served_i,
  output logic       gnt_o,
  output logic       any_o
);
  logic prio_q, prio_d;

  always_comb begin
    any_o  = |req_i;
    // Priority only matters on a tie; a lone requester always wins.
    gnt_o  = (req_i == 2'b11) ? prio_q : req_i[1];
    prio_d = upd_i ? ~served_i : prio_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end
endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one flash read port between two requesters, one read in flight at a time,
// with a watchdog that completes a read with zero data if the flash never answers.
module flash_read_arbiter
  import flash_read_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = FLASH_ADDR_W,
  parameter int unsigned DATA_W  = FLASH_DATA_W,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  flash_read_arbiter_if.slave   bus,
  output logic                  err_timeout,
  output logic                  err_unexpected
);
  localparam int unsigned     CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_to_q, err_to_d;
  logic              err_un_q, err_un_d;

  logic rr_gnt, rr_any;
  logic done, deliver, wd_expired;

  rr_grant2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({bus.m1_read, bus.m0_read}),
    .upd_i    (done),
    .served_i (gnt_q),
    .gnt_o    (rr_gnt),
    .any_o    (rr_any)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    err_to_d   = err_to_q;
    err_un_d   = err_un_q;
    done       = 1'b0;
    deliver    = 1'b0;
    wd_expired = (cnt_q == CNT_MAX);

    unique case (state_q)
      ST_IDLE: begin
        if (rr_any) begin
          gnt_d   = rr_gnt;
          addr_d  = rr_gnt ? bus.m1_address : bus.m0_address;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!bus.flash_mem_waitrequest) begin
          cnt_d   = '0;
          state_d = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        // Real data beats the watchdog when both land in the same cycle.
        if (bus.flash_mem_readdatavalid) begin
          deliver = 1'b1;
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (wd_expired) begin
          deliver  = 1'b1;
          done     = 1'b1;
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.flash_mem_readdatavalid && (state_q != ST_WAIT_DATA)) err_un_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      err_to_q <= 1'b0;
      err_un_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      err_to_q <= err_to_d;
      err_un_q <= err_un_d;
    end
  end

  assign bus.flash_mem_read       = (state_q == ST_ISSUE);
  assign bus.flash_mem_address    = addr_q;
  assign bus.flash_mem_byteenable = FLASH_BYTEENABLE;

  assign bus.m0_waitrequest = (state_q == ST_ISSUE && !gnt_q) ? bus.flash_mem_waitrequest : 1'b1;
  assign bus.m1_waitrequest = (state_q == ST_ISSUE &&  gnt_q) ? bus.flash_mem_waitrequest : 1'b1;

  // A watchdog completion carries zero data; so does any master not being strobed.
  assign bus.m0_readdatavalid = deliver && !gnt_q;
  assign bus.m1_readdatavalid = deliver &&  gnt_q;
  assign bus.m0_readdata = (deliver && !gnt_q && bus.flash_mem_readdatavalid) ? bus.flash_mem_readdata : '0;
  assign bus.m1_readdata = (deliver &&  gnt_q && bus.flash_mem_readdatavalid) ? bus.flash_mem_readdata : '0;

  assign err_timeout    = err_to_q;
  assign err_unexpected = err_un_q;
endmodule

// File: tb/tb_flash_read_arbiter.sv
// Self-checking bench for flash_read_arbiter: vector table, directed corner cases,
// and a randomized run against a transaction-level reference model.
module tb_flash_read_arbiter;
  import flash_read_arbiter_pkg::*;

  localparam int unsigned AW = 23;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_timeout, err_unexpected;

  always #5 clk = ~clk;

  flash_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  flash_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .err_timeout    (err_timeout),
    .err_unexpected (err_unexpected)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic r0; logic [AW-1:0] a0; logic r1; logic [AW-1:0] a1;
    logic fw; logic fv; logic [DW-1:0] fd;
    logic e_fread; logic [AW-1:0] e_faddr;
    logic e_wr0; logic e_wr1; logic e_v0; logic e_v1;
    logic [DW-1:0] e_d0; logic [DW-1:0] e_d1;
    logic e_eto; logic e_eun;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_fread, input logic [AW-1:0] e_faddr,
                          input logic addr_care, input logic e_wr0, input logic e_wr1,
                          input logic e_v0, input logic e_v1,
                          input logic [DW-1:0] e_d0, input logic [DW-1:0] e_d1);
    chk({tag, ".fread"}, 32'(bus.flash_mem_read), 32'(e_fread));
    if (addr_care) chk({tag, ".faddr"}, 32'(bus.flash_mem_address), 32'(e_faddr));
    chk({tag, ".byteen"}, 32'(bus.flash_mem_byteenable), 32'hF);
    chk({tag, ".wr0"}, 32'(bus.m0_waitrequest), 32'(e_wr0));
    chk({tag, ".wr1"}, 32'(bus.m1_waitrequest), 32'(e_wr1));
    chk({tag, ".rdv0"}, 32'(bus.m0_readdatavalid), 32'(e_v0));
    chk({tag, ".rdv1"}, 32'(bus.m1_readdatavalid), 32'(e_v1));
    chk({tag, ".rd0"}, bus.m0_readdata, e_d0);
    chk({tag, ".rd1"}, bus.m1_readdata, e_d1);
  endtask

  task automatic idle_inputs();
    bus.m0_read = 1'b0; bus.m0_address = '0;
    bus.m1_read = 1'b0; bus.m1_address = '0;
    bus.flash_mem_waitrequest = 1'b0;
    bus.flash_mem_readdatavalid = 1'b0;
    bus.flash_mem_readdata = '0;
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk_outs(tag, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    chk({tag, ".eto"}, 32'(err_timeout), 32'h0);
    chk({tag, ".eun"}, 32'(err_unexpected), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int who, input logic r, input logic [AW-1:0] a);
    if (who == 0) begin bus.m0_read = r; bus.m0_address = a; end
    else          begin bus.m1_read = r; bus.m1_address = a; end
  endtask

  // One transaction from an idle arbiter: stall cycles in ISSUE, then lat empty WAIT cycles.
  task automatic txn(input string tag, input int who, input logic [AW-1:0] a, input int stall,
                     input int lat, input bit give, input logic [DW-1:0] d);
    logic [DW-1:0] ed;
    logic last, s_wr;
    @(posedge clk); #1;
    set_req(who, 1'b1, a);
    bus.flash_mem_waitrequest = 1'b0;
    bus.flash_mem_readdatavalid = 1'b0;
    @(negedge clk);
    chk({tag, ".idle_fread"}, 32'(bus.flash_mem_read), 32'h0);
    for (int s = 0; s <= stall; s++) begin
      @(posedge clk); #1;
      bus.flash_mem_waitrequest = (s < stall);
      @(negedge clk);
      s_wr = (s < stall);
      chk_outs($sformatf("%s.issue%0d", tag, s), 1'b1, a, 1'b1,
               (who == 0) ? s_wr : 1'b1, (who == 1) ? s_wr : 1'b1, 1'b0, 1'b0, '0, '0);
    end
    ed = give ? d : '0;
    for (int j = 0; j <= lat; j++) begin
      @(posedge clk); #1;
      set_req(who, 1'b0, '0);
      bus.flash_mem_waitrequest = 1'b1;
      bus.flash_mem_readdatavalid = give && (j == lat);
      bus.flash_mem_readdata = (give && (j == lat)) ? d : 32'hFFFF_FFFF;
      @(negedge clk);
      last = (j == lat);
      chk_outs($sformatf("%s.wait%0d", tag, j), 1'b0, a, 1'b1, 1'b1, 1'b1,
               (who == 0) && last, (who == 1) && last,
               ((who == 0) && last) ? ed : 32'h0, ((who == 1) && last) ? ed : 32'h0);
    end
  endtask

  // Requesters serve address queues and hold read until their own waitrequest drops.
  logic [AW-1:0] q0[$], q1[$], seen[$];
  int n0, n1;

  task automatic run_queues(input string tag);
    int guard = 0;
    bit pend = 1'b0;
    int owner = 0;
    logic [AW-1:0] last_a = '0;
    while ((q0.size() > 0 || q1.size() > 0 || pend) && guard < 100) begin
      @(posedge clk); #1;
      bus.m0_read = (q0.size() > 0); bus.m0_address = (q0.size() > 0) ? q0[0] : '0;
      bus.m1_read = (q1.size() > 0); bus.m1_address = (q1.size() > 0) ? q1[0] : '0;
      bus.flash_mem_waitrequest = 1'b0;
      bus.flash_mem_readdatavalid = pend;
      bus.flash_mem_readdata = 32'(last_a) ^ 32'hA500_0000;
      @(negedge clk);
      if (pend) begin
        chk({tag, ".rdv_owner"}, 32'(owner ? bus.m1_readdatavalid : bus.m0_readdatavalid), 32'h1);
        chk({tag, ".rdv_other"}, 32'(owner ? bus.m0_readdatavalid : bus.m1_readdatavalid), 32'h0);
        chk({tag, ".rdata"}, owner ? bus.m1_readdata : bus.m0_readdata, 32'(last_a) ^ 32'hA500_0000);
        if (bus.m0_readdatavalid) n0++;
        if (bus.m1_readdatavalid) n1++;
        pend = 1'b0;
      end
      if (bus.flash_mem_read && !bus.flash_mem_waitrequest) begin
        seen.push_back(bus.flash_mem_address);
        last_a = bus.flash_mem_address;
        owner = bus.m0_waitrequest ? 1 : 0;
        pend = 1'b1;
      end
      if (!bus.m0_waitrequest && q0.size() > 0) void'(q0.pop_front());
      if (!bus.m1_waitrequest && q1.size() > 0) void'(q1.pop_front());
      guard++;
    end
    chk({tag, ".drained"}, 32'(q0.size() + q1.size()) + 32'(pend), 32'h0);
  endtask

  task automatic fill_table();
    //          r0    a0       r1    a1       fw    fv    fd             fread faddr    wr0   wr1   v0    v1    d0             d1             eto   eun
    vt[0]  = '{1'b1, 23'h10,  1'b0, 23'h0,   1'b0, 1'b0, 32'h0,         1'b0, 23'h0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0};
    vt[1]  = '{1'b1, 23'h10,  1'b0, 23'h0,   1'b0, 1'b0, 32'h0,         1'b1, 23'h10,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0};
    vt[2]  = '{1'b0, 23'h0,   1'b0, 23'h0,   1'b0, 1'b0, 32'hCAFEF00D,  1'b0, 23'h10,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0};
    vt[3]  = '{1'b0, 23'h0,   1'b0, 23'h0,   1'b0, 1'b0, 32'hCAFEF00D,  1'b0, 23'h10,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0};
    vt[4]  = '{1'b0, 23'h0,   1'b0, 23'h0,   1'b0, 1'b1, 32'h1234ABCD,  1'b0, 23'h10,  1'b1, 1'b1, 1'b1, 1'b0, 32'h1234ABCD,  32'h0,         1'b0, 1'b0};
    vt[5]  = '{1'b0, 23'h0,   1'b0, 23'h0,   1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 23'h10,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0};
    vt[6]  = '{1'b0, 23'h0,   1'b0, 23'h0,   1'b0, 1'b0, 32'h0,         1'b0, 23'h10,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1};
    vt[7]  = '{1'b1, 23'h100, 1'b1, 23'h200, 1'b0, 1'b0, 32'h0,         1'b0, 23'h10,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1};
    vt[8]  = '{1'b1, 23'h100, 1'b1, 23'h200, 1'b1, 1'b0, 32'h0,         1'b1, 23'h200, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1};
    vt[9]  = '{1'b1, 23'h100, 1'b1, 23'h200, 1'b0, 1'b0, 32'h0,         1'b1, 23'h200, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1};
    vt[10] = '{1'b1, 23'h100, 1'b0, 23'h0,   1'b0, 1'b1, 32'h55AA55AA,  1'b0, 23'h200, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,         32'h55AA55AA,  1'b0, 1'b1};
    vt[11] = '{1'b1, 23'h100, 1'b0, 23'h0,   1'b0, 1'b0, 32'h0,         1'b0, 23'h200, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1};
    vt[12] = '{1'b1, 23'h100, 1'b0, 23'h0,   1'b0, 1'b0, 32'h0,         1'b1, 23'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1};
    vt[13] = '{1'b0, 23'h0,   1'b0, 23'h0,   1'b0, 1'b1, 32'h0F0F0F0F,  1'b0, 23'h100, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0F0F0F0F,  32'h0,         1'b0, 1'b1};
  endtask

  // Reference model: tracks which requester owns the single outstanding read and
  // predicts every output per cycle from the arbitration rules.
  task automatic random_phase(input int ncyc);
    bit rq[2];
    logic [AW-1:0] ra[2];
    int phase = 0;   // 0 free, 1 read presented to flash, 2 awaiting data
    int owner = 0, mprio = 0, flat = 0;
    logic [AW-1:0] maddr = '0;
    logic fw, fv, iss;
    logic [DW-1:0] fd;
    rq[0] = 1'b0; rq[1] = 1'b0; ra[0] = '0; ra[1] = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++)
        if (!rq[i] && ($urandom_range(1, 0) == 1)) begin rq[i] = 1'b1; ra[i] = AW'($urandom); end
      fw = ($urandom_range(2, 0) == 0);
      fv = (phase == 2) && (flat == 0);
      fd = $urandom;
      bus.m0_read = rq[0]; bus.m0_address = ra[0];
      bus.m1_read = rq[1]; bus.m1_address = ra[1];
      bus.flash_mem_waitrequest = fw;
      bus.flash_mem_readdatavalid = fv;
      bus.flash_mem_readdata = fd;
      @(negedge clk);
      iss = (phase == 1);
      chk_outs($sformatf("rnd%0d", c), iss, maddr, iss,
               (iss && owner == 0) ? fw : 1'b1, (iss && owner == 1) ? fw : 1'b1,
               fv && owner == 0, fv && owner == 1,
               (fv && owner == 0) ? fd : 32'h0, (fv && owner == 1) ? fd : 32'h0);
      case (phase)
        0: if (rq[0] || rq[1]) begin
             owner = (rq[0] && rq[1]) ? mprio : (rq[1] ? 1 : 0);
             maddr = ra[owner];
             phase = 1;
           end
        1: if (!fw) begin rq[owner] = 1'b0; flat = $urandom_range(4, 0); phase = 2; end
        default: if (fv) begin mprio = 1 - owner; phase = 0; end else flat--;
      endcase
    end
    chk("rnd.eto", 32'(err_timeout), 32'h0);
    chk("rnd.eun", 32'(err_unexpected), 32'h0);
  endtask

  initial begin
    logic [AW-1:0] exp_order [5];
    exp_order[0] = 23'h10; exp_order[1] = 23'h20; exp_order[2] = 23'h30;
    exp_order[3] = 23'h60; exp_order[4] = 23'h50;

    do_reset("rst0");

    fill_table();
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      bus.m0_read = vt[i].r0; bus.m0_address = vt[i].a0;
      bus.m1_read = vt[i].r1; bus.m1_address = vt[i].a1;
      bus.flash_mem_waitrequest = vt[i].fw;
      bus.flash_mem_readdatavalid = vt[i].fv;
      bus.flash_mem_readdata = vt[i].fd;
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), vt[i].e_fread, vt[i].e_faddr, 1'b1, vt[i].e_wr0, vt[i].e_wr1,
               vt[i].e_v0, vt[i].e_v1, vt[i].e_d0, vt[i].e_d1);
      chk($sformatf("vec%0d.eto", i), 32'(err_timeout), 32'(vt[i].e_eto));
      chk($sformatf("vec%0d.eun", i), 32'(err_unexpected), 32'(vt[i].e_eun));
    end

    // Arbitration order: tie after reset goes to m0, then strict alternation.
    do_reset("rst1");
    n0 = 0; n1 = 0; seen.delete();
    q0 = '{23'h10, 23'h30}; q1 = '{23'h20};
    run_queues("arbA");
    idle_inputs();
    repeat (2) @(posedge clk);
    q0 = '{23'h50}; q1 = '{23'h60};
    run_queues("arbB");
    chk("arb.count", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("arb.order%0d", i), (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
    chk("arb.n0", 32'(n0), 32'd3);
    chk("arb.n1", 32'(n1), 32'd2);

    // Flash stall of 5 cycles while m1 holds the grant.
    do_reset("rst2");
    txn("stall", 1, 23'h77, 5, 1, 1'b1, 32'hA1B2C3D4);

    // Watchdog: data in the final cycle wins; silence yields a zero completion.
    txn("dwin", 0, 23'h33, 0, TO - 1, 1'b1, 32'h600DDA7A);
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    chk("dwin.eto", 32'(err_timeout), 32'h0);
    txn("tout", 0, 23'h34, 1, TO - 1, 1'b0, 32'h0);
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    chk("tout.eto", 32'(err_timeout), 32'h1);
    chk("tout.eun", 32'(err_unexpected), 32'h0);
    chk("tout.fread", 32'(bus.flash_mem_read), 32'h0);
    txn("after_to", 1, 23'h35, 0, 0, 1'b1, 32'h13572468);

    // Async reset during WAIT_DATA, stray data afterwards, then normal service.
    @(posedge clk); #1; idle_inputs(); set_req(1, 1'b1, 23'h44);
    @(posedge clk); #1;
    @(posedge clk); #1; set_req(1, 1'b0, '0);
    @(negedge clk);
    chk("mid.fread", 32'(bus.flash_mem_read), 32'h0);
    @(posedge clk); #1;
    do_reset("rst3");
    @(posedge clk); #1;
    bus.flash_mem_readdatavalid = 1'b1; bus.flash_mem_readdata = 32'hBAADF00D;
    @(negedge clk);
    chk("stray.rdv0", 32'(bus.m0_readdatavalid), 32'h0);
    chk("stray.rdv1", 32'(bus.m1_readdatavalid), 32'h0);
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    chk("stray.eun", 32'(err_unexpected), 32'h1);
    txn("post_rst", 1, 23'h46, 2, 1, 1'b1, 32'h89ABCDEF);

    do_reset("rst4");
    random_phase(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit reached");
  end
endmodule
